// File: rtl/exe_mem_pkg.sv
// rtl/exe_mem_pkg.sv - shared types and constants for the EX->MEM skid pipeline
// Purpose: control-bit struct, occupancy state enum, reference payload layout
//          and the control-gating helper used by exe_mem_skid_pipe.
// Ports:   none (package).
package exe_mem_pkg;

  localparam int EM_WORD_W = 32;
  localparam int EM_REG_AW = 4;
  localparam int EM_LANES  = 9;
  localparam int EM_LANE_W = 9;
  localparam int EM_IDX_W  = 4;

  // Bit order matters: pc_src is the MSB when the struct is flattened.
  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic link;
    logic mem_write_v;
    logic reg_write_v;
    logic reg_write_vv;
  } ctrl_t;

  localparam int    CTRL_W    = $bits(ctrl_t);
  localparam ctrl_t CTRL_ZERO = '0;

  // EMPTY: nothing held, ONE: MAIN only, TWO: MAIN + SKID.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Payload for the default configuration, field for field with the e_*/m_* ports.
  typedef struct packed {
    ctrl_t                                  ctrl;
    logic [EM_WORD_W-1:0]                   alu_result;
    logic [EM_WORD_W-1:0]                   write_data;
    logic [EM_WORD_W-1:0]                   pc_plus4;
    logic [EM_REG_AW-1:0]                   wa3;
    logic [EM_LANES-1:0][EM_LANE_W-1:0]     wdata_v;
    logic [EM_IDX_W-1:0]                    idx;
  } payload_t;

  // An empty stage must never present an active control bit to MEM.
  function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic v);
    return v ? c : CTRL_ZERO;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one payload register with load enable and sync clear
// Purpose: storage for one pipeline entry (used for both MAIN and SKID).
// Ports:   clk_i   - clock, rising edge
//          clear_i - synchronous clear to zero, wins over load_i
//          load_i  - capture d_i on this edge
//          d_i     - payload in (W bits)
//          q_o     - stored payload (W bits)
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/exe_mem_skid_pipe.sv
// rtl/exe_mem_skid_pipe.sv - EX->MEM pipeline register with 2-entry skid buffer
// Purpose: carries scalar/vector control and data from execute to memory with a
//          valid/ready handshake at full throughput; e_ready depends only on the
//          registered occupancy, so there is no combinational path from m_ready.
// Ports:   clk, reset (sync, active-high), flush (squash held entries)
//          e_valid/e_ready + e_ctrl, e_alu_result, e_write_data, e_pc_plus4,
//            e_wa3, e_wdata_v[LANES], e_index        - EX side
//          m_valid/m_ready + m_* counterparts          - MEM side
//          stall_cnt, bubble_cnt                       - performance counters
// Config:  EXE_MEM_PERF_EN enables the saturating counters; without it both
//          counter outputs are tied to zero.
module exe_mem_skid_pipe
  import exe_mem_pkg::*;
#(
  parameter int WORD_W = EM_WORD_W,
  parameter int REG_AW = EM_REG_AW,
  parameter int LANES  = EM_LANES,
  parameter int LANE_W = EM_LANE_W,
  parameter int IDX_W  = EM_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     e_valid,
  output logic                     e_ready,
  input  ctrl_t                    e_ctrl,
  input  logic [WORD_W-1:0]        e_alu_result,
  input  logic [WORD_W-1:0]        e_write_data,
  input  logic [WORD_W-1:0]        e_pc_plus4,
  input  logic [REG_AW-1:0]        e_wa3,
  input  logic signed [LANE_W-1:0] e_wdata_v [LANES],
  input  logic [IDX_W-1:0]         e_index,
  output logic                     m_valid,
  input  logic                     m_ready,
  output ctrl_t                    m_ctrl,
  output logic [WORD_W-1:0]        m_alu_result,
  output logic [WORD_W-1:0]        m_write_data,
  output logic [WORD_W-1:0]        m_pc_plus4,
  output logic [REG_AW-1:0]        m_wa3,
  output logic signed [LANE_W-1:0] m_wdata_v [LANES],
  output logic [IDX_W-1:0]         m_index,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              bubble_cnt
);

  // Flat payload layout, LSB first: index, lanes, wa3, pc+4, store data, alu, ctrl.
  localparam int LANES_W = LANES * LANE_W;
  localparam int IDX_LO  = 0;
  localparam int LN_LO   = IDX_LO + IDX_W;
  localparam int WA_LO   = LN_LO + LANES_W;
  localparam int PC_LO   = WA_LO + REG_AW;
  localparam int WD_LO   = PC_LO + WORD_W;
  localparam int AL_LO   = WD_LO + WORD_W;
  localparam int CT_LO   = AL_LO + WORD_W;
  localparam int PAY_W   = CT_LO + CTRL_W;

  state_t             state_q;
  state_t             state_d;
  logic               acc;
  logic               rel;
  logic               main_load;
  logic               main_from_skid;
  logic               skid_load;
  logic [LANES_W-1:0] e_lanes_flat;
  logic [PAY_W-1:0]   e_flat;
  logic [PAY_W-1:0]   main_d;
  logic [PAY_W-1:0]   main_q;
  logic [PAY_W-1:0]   skid_q;

  always_comb begin
    e_lanes_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      e_lanes_flat[i*LANE_W +: LANE_W] = e_wdata_v[i];
    end
  end

  assign e_flat = {e_ctrl, e_alu_result, e_write_data, e_pc_plus4, e_wa3, e_lanes_flat, e_index};

  assign m_valid = (state_q != EMPTY);
  assign e_ready = (state_q != TWO);
  assign acc     = e_valid & e_ready;
  assign rel     = m_valid & m_ready;

  // Occupancy FSM. Flush only moves the state; entry data is left in place
  // because m_ctrl gating already makes an empty stage harmless.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (acc && !rel) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (rel && !acc) begin
            state_d = EMPTY;
          end else if (acc && rel) begin
            main_load = 1'b1;
          end
        end
        TWO: begin
          // e_ready is low here, so only a release can happen.
          if (rel) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : e_flat;

  pipe_skid_entry #(.W(PAY_W)) u_main (
    .clk_i   (clk),
    .clear_i (reset),
    .load_i  (main_load),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  pipe_skid_entry #(.W(PAY_W)) u_skid (
    .clk_i   (clk),
    .clear_i (reset),
    .load_i  (skid_load),
    .d_i     (e_flat),
    .q_o     (skid_q)
  );

  assign m_ctrl       = ctrl_gate(ctrl_t'(main_q[CT_LO +: CTRL_W]), m_valid);
  assign m_alu_result = main_q[AL_LO +: WORD_W];
  assign m_write_data = main_q[WD_LO +: WORD_W];
  assign m_pc_plus4   = main_q[PC_LO +: WORD_W];
  assign m_wa3        = main_q[WA_LO +: REG_AW];
  assign m_index      = main_q[IDX_LO +: IDX_W];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      m_wdata_v[i] = $signed(main_q[LN_LO + i*LANE_W +: LANE_W]);
    end
  end

`ifdef EXE_MEM_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_valid && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!m_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_mem_skid_pipe.sv
// tb/tb_exe_mem_skid_pipe.sv - self-checking bench for exe_mem_skid_pipe
module tb_exe_mem_skid_pipe;
  import exe_mem_pkg::*;

  localparam int LANES  = EM_LANES;
  localparam int LANE_W = EM_LANE_W;
`ifdef EXE_MEM_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                     clk;
  logic                     reset;
  logic                     flush;
  logic                     e_valid;
  logic                     e_ready;
  ctrl_t                    e_ctrl;
  logic [EM_WORD_W-1:0]     e_alu_result;
  logic [EM_WORD_W-1:0]     e_write_data;
  logic [EM_WORD_W-1:0]     e_pc_plus4;
  logic [EM_REG_AW-1:0]     e_wa3;
  logic signed [LANE_W-1:0] e_wdata_v [LANES];
  logic [EM_IDX_W-1:0]      e_index;
  logic                     m_valid;
  logic                     m_ready;
  ctrl_t                    m_ctrl;
  logic [EM_WORD_W-1:0]     m_alu_result;
  logic [EM_WORD_W-1:0]     m_write_data;
  logic [EM_WORD_W-1:0]     m_pc_plus4;
  logic [EM_REG_AW-1:0]     m_wa3;
  logic signed [LANE_W-1:0] m_wdata_v [LANES];
  logic [EM_IDX_W-1:0]      m_index;
  logic [31:0]              stall_cnt;
  logic [31:0]              bubble_cnt;

  exe_mem_skid_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .e_valid      (e_valid),
    .e_ready      (e_ready),
    .e_ctrl       (e_ctrl),
    .e_alu_result (e_alu_result),
    .e_write_data (e_write_data),
    .e_pc_plus4   (e_pc_plus4),
    .e_wa3        (e_wa3),
    .e_wdata_v    (e_wdata_v),
    .e_index      (e_index),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_ctrl       (m_ctrl),
    .m_alu_result (m_alu_result),
    .m_write_data (m_write_data),
    .m_pc_plus4   (m_pc_plus4),
    .m_wa3        (m_wa3),
    .m_wdata_v    (m_wdata_v),
    .m_index      (m_index),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  payload_t    cur;
  payload_t    model_q[$];
  logic [31:0] mdl_stall;
  logic [31:0] mdl_bubble;

  typedef struct {
    bit          rst;
    bit          fl;
    bit          ev;
    bit          mr;
    bit          rw;
    logic [31:0] alu;
    logic [3:0]  wa3;
    bit          x_mv;
    bit          x_er;
    bit          x_rw;
    bit          x_chk;
    logic [31:0] x_alu;
    logic [3:0]  x_wa3;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit fl, bit ev, bit mr, bit rw, logic [31:0] alu,
                              logic [3:0] wa3, bit x_mv, bit x_er, bit x_rw, bit x_chk,
                              logic [31:0] x_alu, logic [3:0] x_wa3);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ev = ev; v.mr = mr; v.rw = rw; v.alu = alu; v.wa3 = wa3;
    v.x_mv = x_mv; v.x_er = x_er; v.x_rw = x_rw; v.x_chk = x_chk; v.x_alu = x_alu; v.x_wa3 = x_wa3;
    return v;
  endfunction

  function automatic payload_t tbl_pl(bit rw, logic [31:0] alu, logic [3:0] wa3);
    payload_t p;
    p = '0;
    p.ctrl.reg_write = rw;
    p.alu_result     = alu;
    p.write_data     = ~alu;
    p.pc_plus4       = alu + 32'd4;
    p.wa3            = wa3;
    for (int i = 0; i < LANES; i++) p.wdata_v[i] = alu[8:0] + 9'(i);
    p.idx            = alu[3:0];
    return p;
  endfunction

  function automatic payload_t rand_pl();
    payload_t p;
    p.ctrl       = ctrl_t'(8'($urandom_range(0, 255)));
    p.alu_result = $urandom();
    p.write_data = $urandom();
    p.pc_plus4   = $urandom();
    p.wa3        = 4'($urandom_range(0, 15));
    for (int i = 0; i < LANES; i++) p.wdata_v[i] = 9'($urandom_range(0, 511));
    p.idx        = 4'($urandom_range(0, 15));
    return p;
  endfunction

  function automatic payload_t dut_payload();
    payload_t p;
    p.ctrl       = m_ctrl;
    p.alu_result = m_alu_result;
    p.write_data = m_write_data;
    p.pc_plus4   = m_pc_plus4;
    p.wa3        = m_wa3;
    for (int i = 0; i < LANES; i++) p.wdata_v[i] = m_wdata_v[i];
    p.idx        = m_index;
    return p;
  endfunction

  task automatic drive(input bit rst, input bit fl, input bit ev, input bit mr, input payload_t p);
    reset        = rst;
    flush        = fl;
    e_valid      = ev;
    m_ready      = mr;
    cur          = p;
    e_ctrl       = p.ctrl;
    e_alu_result = p.alu_result;
    e_write_data = p.write_data;
    e_pc_plus4   = p.pc_plus4;
    e_wa3        = p.wa3;
    for (int i = 0; i < LANES; i++) e_wdata_v[i] = p.wdata_v[i];
    e_index      = p.idx;
  endtask

  // Reference: a FIFO of at most two payloads. Head is what MEM sees.
  task automatic cycle();
    int       n;
    bit       acc;
    bit       rel;
    payload_t dropped;
    n   = model_q.size();
    acc = e_valid && (n < 2);
    rel = (n > 0) && m_ready;
    if (reset) begin
      model_q.delete();
      mdl_stall  = '0;
      mdl_bubble = '0;
    end else begin
      if (n > 0 && !m_ready) mdl_stall++;
      if (n == 0) mdl_bubble++;
      if (flush) begin
        model_q.delete();
      end else begin
        if (rel) dropped = model_q.pop_front();
        if (acc) model_q.push_back(cur);
      end
    end
    @(posedge clk);
    #1;
    check("m_valid", 256'(m_valid), 256'(model_q.size() > 0));
    check("e_ready", 256'(e_ready), 256'(model_q.size() < 2));
    if (model_q.size() > 0) check("payload", 256'(dut_payload()), 256'(model_q[0]));
    else check("m_ctrl_empty", 256'(m_ctrl), 256'(0));
    check("stall_cnt", 256'(stall_cnt), PERF ? 256'(mdl_stall) : 256'(0));
    check("bubble_cnt", 256'(bubble_cnt), PERF ? 256'(mdl_bubble) : 256'(0));
  endtask

  initial begin
    payload_t p;
    vectors     = 0;
    miscompares = 0;
    mdl_stall   = '0;
    mdl_bubble  = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    //           rst fl ev mr rw alu       wa3    mv er rw chk x_alu     x_wa3
    tbl[0]  = mk(1, 0, 1, 0, 1, 32'd99,   4'h5,  0, 1, 0, 1, 32'd0,    4'h0);
    tbl[1]  = mk(1, 0, 1, 0, 1, 32'd99,   4'h5,  0, 1, 0, 1, 32'd0,    4'h0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 32'd1,    4'h1,  1, 1, 0, 1, 32'd1,    4'h1);
    tbl[3]  = mk(0, 0, 1, 1, 0, 32'd2,    4'h2,  1, 1, 0, 1, 32'd2,    4'h2);
    tbl[4]  = mk(0, 0, 1, 1, 0, 32'd3,    4'h3,  1, 1, 0, 1, 32'd3,    4'h3);
    tbl[5]  = mk(0, 0, 0, 1, 0, 32'd0,    4'h0,  0, 1, 0, 0, 32'd0,    4'h0);
    tbl[6]  = mk(0, 0, 1, 0, 0, 32'hA0,   4'h0,  1, 1, 0, 1, 32'hA0,   4'h0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 32'hB0,   4'h0,  1, 0, 0, 1, 32'hA0,   4'h0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 32'hC0,   4'h0,  1, 0, 0, 1, 32'hA0,   4'h0);
    tbl[9]  = mk(0, 0, 1, 1, 0, 32'hC0,   4'h0,  1, 1, 0, 1, 32'hB0,   4'h0);
    tbl[10] = mk(0, 0, 1, 1, 0, 32'hC0,   4'h0,  1, 1, 0, 1, 32'hC0,   4'h0);
    tbl[11] = mk(0, 0, 0, 1, 0, 32'd0,    4'h0,  0, 1, 0, 0, 32'd0,    4'h0);
    tbl[12] = mk(0, 0, 1, 0, 1, 32'd11,   4'h1,  1, 1, 1, 1, 32'd11,   4'h1);
    tbl[13] = mk(0, 0, 1, 0, 1, 32'd12,   4'h2,  1, 0, 1, 1, 32'd11,   4'h1);
    tbl[14] = mk(0, 1, 1, 0, 1, 32'd13,   4'h3,  0, 1, 0, 0, 32'd0,    4'h0);
    tbl[15] = mk(0, 0, 0, 0, 0, 32'd0,    4'h0,  0, 1, 0, 0, 32'd0,    4'h0);
    tbl[16] = mk(0, 0, 1, 0, 0, 32'd21,   4'h3,  1, 1, 0, 1, 32'd21,   4'h3);
    tbl[17] = mk(0, 0, 1, 1, 0, 32'd22,   4'hA,  1, 1, 0, 1, 32'd22,   4'hA);
    tbl[18] = mk(0, 0, 0, 1, 0, 32'd0,    4'h0,  0, 1, 0, 0, 32'd0,    4'h0);

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].ev, tbl[i].mr, tbl_pl(tbl[i].rw, tbl[i].alu, tbl[i].wa3));
      cycle();
      check($sformatf("tbl%0d_m_valid", i), 256'(m_valid), 256'(tbl[i].x_mv));
      check($sformatf("tbl%0d_e_ready", i), 256'(e_ready), 256'(tbl[i].x_er));
      check($sformatf("tbl%0d_reg_write", i), 256'(m_ctrl.reg_write), 256'(tbl[i].x_rw));
      if (tbl[i].x_chk) begin
        check($sformatf("tbl%0d_alu", i), 256'(m_alu_result), 256'(tbl[i].x_alu));
        check($sformatf("tbl%0d_wa3", i), 256'(m_wa3), 256'(tbl[i].x_wa3));
      end
    end

    // Extreme lane values held under back-pressure for five cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    p = '0;
    p.wdata_v[0] = 9'h100;
    p.wdata_v[1] = 9'h0FF;
    drive(1'b0, 1'b0, 1'b1, 1'b0, p);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, rand_pl());
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("hold_lane0", 256'($unsigned(m_wdata_v[0])), 256'(9'h100));
      check("hold_lane1", 256'($unsigned(m_wdata_v[1])), 256'(9'h0FF));
      check("hold_lane2", 256'($unsigned(m_wdata_v[2])), 256'(9'h000));
    end
    check("hold_stall_cnt", 256'(stall_cnt), PERF ? 256'(5) : 256'(0));
    check("hold_bubble_cnt", 256'(bubble_cnt), PERF ? 256'(1) : 256'(0));

    // Random traffic against the FIFO reference.
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rand_pl());
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
